// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that serialises single-beat requests from NUM_REQ
// requesters onto one APB master port, bounding PREADY stalls with a timeout.
module apb_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_error,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  output logic                          PWRITE,
  output logic                          PSEL,
  output logic                          PENABLE,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERROR
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        rr_ptr_q;
  logic [IDX_W-1:0]        gnt_idx_q;
  logic [TMO_W-1:0]        tmo_cnt_q;
  logic [NUM_REQ-1:0]      req_ready_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_error_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic                    pwrite_q;
  logic                    psel_q;
  logic                    penable_q;

  logic [IDX_W-1:0]        winner_d;
  logic [IDX_W-1:0]        rr_ptr_d;
  logic                    timeout_hit;

  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Scan from the farthest offset down so the nearest requester to rr_ptr wins.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    winner_d = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[rr_index(rr_ptr_q, i)]) winner_d = rr_index(rr_ptr_q, i);
    end
    rr_ptr_d = (winner_d == IDX_W'(NUM_REQ - 1)) ? '0 : winner_d + IDX_W'(1);
  end

  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT_CYCLES != 0) timeout_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  end

  // NOTE: reset is synchronous and clears every register, outputs included;
  // state updates use non-blocking assignments only.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      tmo_cnt_q   <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            paddr_q     <= req_addr[int'(winner_d)*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata_q    <= req_wdata[int'(winner_d)*DATA_WIDTH +: DATA_WIDTH];
            pwrite_q    <= req_write[winner_d];
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            req_ready_q <= NUM_REQ'(1) << winner_d;
            gnt_idx_q   <= winner_d;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          tmo_cnt_q <= '0;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            rsp_error_q <= PSLVERROR;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= NUM_REQ'(1) << gnt_idx_q;
            state_q     <= S_RESP;
          end else if (timeout_hit) begin
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= NUM_REQ'(1) << gnt_idx_q;
            state_q     <= S_RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;

endmodule
